// File: rtl/mxu_host_ctrl.sv
// Host-side sequencer for the matrix unit: streams A/B operands into its cache, kicks it off, then drains results.
// Optional wait-for-done watchdog enabled by defining MXU_HOST_TIMEOUT_EN.
module mxu_host_ctrl #(
  parameter int SIZE           = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic [31:0] awaddr,
  output logic [8:0]  wdata,
  output logic        awready,
  output logic        wready,
  input  logic        mxu_done,
  output logic [31:0] araddr,
  input  logic [31:0] rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic        m_last,
  output logic        busy,
  output logic        timeout
);

  // state | meaning
  // LOAD  | accept operand bytes, one cache write per byte
  // START | issue the go command (addr 0, data 1)
  // WAIT  | wait for mxu_done
  // READ  | present result index on araddr
  // CAPT  | capture rdata into the output register
  // OUT   | hold result until the sink takes it

  localparam int NB = 2 * SIZE * SIZE;
  localparam int NW = SIZE * SIZE;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic [2:0] {LOAD, START, WAIT, READ, CAPT, OUT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   idx_nxt;

  assign idx_nxt = idx + IW'(1);
  assign busy    = !(state == LOAD && cnt == '0);

`ifdef MXU_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr;
  logic          timeout_q;
  assign timeout = timeout_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LOAD;
      cnt     <= '0;
      idx     <= '0;
      s_ready <= 1'b0;
      awaddr  <= '0;
      wdata   <= '0;
      awready <= 1'b0;
      wready  <= 1'b0;
      araddr  <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
`ifdef MXU_HOST_TIMEOUT_EN
      tmr       <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      awready <= 1'b0;
      wready  <= 1'b0;
      case (state)
        LOAD: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            awaddr  <= 32'(cnt) + 32'd1;
            wdata   <= {1'b0, s_data};
            awready <= 1'b1;
            wready  <= 1'b1;
            if (cnt == CW'(NB - 1)) begin
              cnt     <= '0;
              s_ready <= 1'b0;
              state   <= START;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        START: begin
          awaddr  <= '0;
          wdata   <= 9'h001;
          awready <= 1'b1;
          wready  <= 1'b1;
          state   <= WAIT;
`ifdef MXU_HOST_TIMEOUT_EN
          tmr <= TW'(TIMEOUT_CYCLES - 1);
`endif
        end
        WAIT: begin
          if (mxu_done) begin
            idx    <= '0;
            araddr <= '0;
            state  <= READ;
          end
`ifdef MXU_HOST_TIMEOUT_EN
          // Down-counter hits zero on the TIMEOUT_CYCLES-th WAIT cycle.
          else if (tmr == '0) begin
            timeout_q <= 1'b1;
            s_ready   <= 1'b1;
            state     <= LOAD;
          end else begin
            tmr <= tmr - TW'(1);
          end
`endif
        end
        READ: begin
          state <= CAPT;
        end
        CAPT: begin
          m_data  <= rdata;
          m_valid <= 1'b1;
          m_last  <= (idx == IW'(NW - 1));
          state   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              s_ready <= 1'b1;
              state   <= LOAD;
            end else begin
              // araddr tracks idx from the first READ cycle so rdata is settled by CAPT.
              idx    <= idx_nxt;
              araddr <= 32'(idx_nxt);
              state  <= READ;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mxu_host_ctrl.sv
// Directed bench for mxu_host_ctrl: vector table for gapped operand loading plus hand sequences for jobs, stalls and reset.
module tb_mxu_host_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic [31:0] awaddr;
  logic [8:0]  wdata;
  logic        awready;
  logic        wready;
  logic        mxu_done = 1'b0;
  logic [31:0] araddr;
  logic [31:0] rdata;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_data;
  logic        m_last;
  logic        busy;
  logic        timeout;

  int n_err = 0;
  int n_chk = 0;

  mxu_host_ctrl #(.SIZE(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .awaddr(awaddr), .wdata(wdata), .awready(awready), .wready(wready),
    .mxu_done(mxu_done), .araddr(araddr), .rdata(rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .timeout(timeout)
  );

  // Matrix unit result model: word k holds 3*k.
  assign rdata = araddr * 32'd3;

  always #5 clk = ~clk;

  typedef struct {
    logic        s_valid;
    logic [7:0]  s_data;
    logic        mxu_done;
    logic        exp_strb;
    logic [31:0] exp_awaddr;
    logic [8:0]  exp_wdata;
  } vec_t;

  vec_t vecs[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Streams bytes first..31 of a job (data base+i), then checks the start command and entry into WAIT.
  task automatic load_bytes(input int first, input int base);
    s_valid = 1'b1;
    for (int i = first; i < 32; i++) begin
      s_data = 8'(base + i);
      tick();
      chk("load_awready", awready, 1);
      chk("load_wready", wready, 1);
      chk("load_awaddr", awaddr, 32'(i + 1));
      chk("load_wdata", wdata, 32'(9'(8'(base + i))));
      chk("load_s_ready", s_ready, (i < 31) ? 1 : 0);
    end
    tick();
    chk("start_awaddr", awaddr, 0);
    chk("start_wdata", wdata, 32'h001);
    chk("start_strobe", {awready, wready}, 2'b11);
    s_valid = 1'b0;
    tick();
    chk("wait_strobe", {awready, wready}, 2'b00);
    chk("wait_s_ready", s_ready, 0);
    chk("wait_busy", busy, 1);
  endtask

  // Entered with the FSM in READ at word 'first'; optionally stalls first and last word.
  task automatic run_words(input int first, input int stall_n);
    for (int k = first; k < 16; k++) begin
      tick();
      chk("capt_m_valid", m_valid, 0);
      chk("capt_araddr", araddr, 32'(k));
      tick();
      chk("out_m_valid", m_valid, 1);
      chk("out_m_data", m_data, 32'(3 * k));
      chk("out_m_last", m_last, (k == 15) ? 1 : 0);
      if (stall_n > 0 && (k == 0 || k == 15)) begin
        m_ready  = 1'b0;
        mxu_done = 1'b1;
        for (int s = 0; s < stall_n; s++) begin
          tick();
          chk("stall_m_valid", m_valid, 1);
          chk("stall_m_data", m_data, 32'(3 * k));
          chk("stall_m_last", m_last, (k == 15) ? 1 : 0);
          chk("stall_araddr", araddr, 32'(k));
        end
        m_ready  = 1'b1;
        mxu_done = 1'b0;
      end
      tick();
      chk("hs_m_valid", m_valid, 0);
      if (k < 15) begin
        chk("next_araddr", araddr, 32'(k + 1));
        chk("next_s_ready", s_ready, 0);
      end else begin
        chk("done_s_ready", s_ready, 1);
        chk("done_busy", busy, 0);
        chk("done_m_last", m_last, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 32'd1,  9'h011};
    vecs[1]  = '{1'b0, 8'h22, 1'b1, 1'b0, 32'd1,  9'h011};
    vecs[2]  = '{1'b1, 8'h80, 1'b1, 1'b1, 32'd2,  9'h080};
    vecs[3]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 32'd3,  9'h0FF};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 32'd3,  9'h0FF};
    vecs[5]  = '{1'b1, 8'h05, 1'b0, 1'b1, 32'd4,  9'h005};
    vecs[6]  = '{1'b1, 8'h06, 1'b0, 1'b1, 32'd5,  9'h006};
    vecs[7]  = '{1'b1, 8'h07, 1'b0, 1'b1, 32'd6,  9'h007};
    vecs[8]  = '{1'b0, 8'h99, 1'b1, 1'b0, 32'd6,  9'h007};
    vecs[9]  = '{1'b1, 8'h08, 1'b0, 1'b1, 32'd7,  9'h008};
    vecs[10] = '{1'b1, 8'h09, 1'b0, 1'b1, 32'd8,  9'h009};
    vecs[11] = '{1'b1, 8'h0A, 1'b0, 1'b1, 32'd9,  9'h00A};
    vecs[12] = '{1'b1, 8'hAB, 1'b0, 1'b1, 32'd10, 9'h0AB};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 32'd10, 9'h0AB};

    // Reset state
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", {awready, wready}, 2'b00);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b1;
    #1;
    chk("rel_s_ready", s_ready, 0);
    tick();
    chk("rel_s_ready_1clk", s_ready, 1);
    chk("rel_busy", busy, 0);

    // Job A: 0x01..0x20 back to back, results drained at full rate
    load_bytes(0, 1);
    mxu_done = 1'b1;
    tick();
    mxu_done = 1'b0;
    chk("a_read_araddr", araddr, 0);
    run_words(0, 0);

    // Job B: gapped bytes from the vector table, mxu_done noise during LOAD
    for (int v = 0; v < 14; v++) begin
      s_valid  = vecs[v].s_valid;
      s_data   = vecs[v].s_data;
      mxu_done = vecs[v].mxu_done;
      tick();
      chk("vec_strobe", {awready, wready}, {vecs[v].exp_strb, vecs[v].exp_strb});
      chk("vec_awaddr", awaddr, vecs[v].exp_awaddr);
      chk("vec_wdata", 32'(wdata), 32'(vecs[v].exp_wdata));
      chk("vec_s_ready", s_ready, 1);
      chk("vec_busy", busy, 1);
    end
    mxu_done = 1'b0;

    // Asynchronous reset after 10 bytes
    reset = 1'b0;
    #1;
    chk("arst_awaddr", awaddr, 0);
    chk("arst_wdata", 32'(wdata), 0);
    chk("arst_araddr", araddr, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_flags", {awready, wready, m_valid, m_last, busy, timeout, s_ready}, 0);
    repeat (2) tick();
    chk("arst_hold_strobe", {awready, wready}, 2'b00);
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h5A;
    tick();
    chk("post_rst_no_write", {awready, wready}, 2'b00);
    chk("post_rst_s_ready", s_ready, 1);
    tick();
    chk("post_rst_awaddr", awaddr, 1);
    chk("post_rst_wdata", 32'(wdata), 32'h05A);
    chk("post_rst_strobe", {awready, wready}, 2'b11);

    // Job C: finish loading, then wait behaviour, then stalled drain
    load_bytes(1, 8'h40);
`ifdef MXU_HOST_TIMEOUT_EN
    repeat (14) tick();
    chk("to_not_yet", timeout, 0);
    tick();
    chk("to_set", timeout, 1);
    chk("to_s_ready", s_ready, 1);
    load_bytes(0, 8'h60);
    chk("to_sticky", timeout, 1);
`else
    repeat (40) tick();
    chk("wait_no_timeout", timeout, 0);
    chk("wait_persist_s_ready", s_ready, 0);
    chk("wait_persist_busy", busy, 1);
    chk("wait_persist_mvalid", m_valid, 0);
`endif
    mxu_done = 1'b1;
    tick();
    mxu_done = 1'b0;
    chk("c_read_araddr", araddr, 0);
    run_words(0, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mxu_host_ctrl.md
MXU_HOST_CTRL -- requirements
Module: mxu_host_ctrl

Interface
REQ-001 Parameter SIZE, default 4, matrix dimension; SHALL equal the SIZE of the attached matrix unit.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, wait-for-done limit; used only when MXU_HOST_TIMEOUT_EN is defined.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 s_valid  input  1  operand byte valid.
REQ-006 s_ready  output  1  operand byte accepted when s_valid and s_ready are both high.
REQ-007 s_data  input  8  operand byte: 2*SIZE*SIZE bytes per job, A row-major then B row-major.
REQ-008 awaddr  output  32  write address to the matrix unit cache.
REQ-009 wdata  output  9  write data; bit 8 SHALL always be 0.
REQ-010 awready, wready  output  1 each  write strobes; both high means a write.
REQ-011 mxu_done  input  1  matrix unit completion pulse or level.
REQ-012 araddr  output  32  result select to the matrix unit.
REQ-013 rdata  input  32  result word from the matrix unit.
REQ-014 m_valid, m_ready  output/input  1 each  result stream handshake.
REQ-015 m_data  output  32  result word.
REQ-016 m_last  output  1  high with the final (SIZE*SIZE-th) result of a job.
REQ-017 busy  output  1  high in every state except LOAD with a byte count of 0.

Function
REQ-018 The FSM SHALL have states LOAD, START, WAIT, READ, CAPT, OUT.
REQ-019 LOAD: s_ready=1; each handshake SHALL register awaddr=cnt+1, wdata={0,s_data}, and assert awready=wready=1 for exactly the next cycle; cnt SHALL then increment.
REQ-020 On the handshake with cnt=2*SIZE*SIZE-1, the FSM SHALL go to START and cnt SHALL clear.
REQ-021 START (one cycle): awaddr=0, wdata=9'h001, strobes high; next state WAIT.
REQ-022 s_ready SHALL be 0 in every state other than LOAD.
REQ-023 WAIT: mxu_done sampled high SHALL move to READ with idx=0; strobes stay low.
REQ-024 READ: araddr=idx (zero-extended); next state CAPT.
REQ-025 CAPT: m_data<=rdata, m_valid<=1, m_last<=(idx==SIZE*SIZE-1); next state OUT.
REQ-026 OUT: m_data, m_valid and m_last SHALL hold stable until m_ready; on m_valid&m_ready, m_valid SHALL drop the next cycle.
REQ-027 On that OUT handshake, a non-last word SHALL increment idx and go to READ; the last word SHALL go to LOAD.
REQ-028 Minimum result throughput SHALL be one word per 3 cycles.
REQ-029 mxu_done outside WAIT SHALL be ignored.
REQ-030 awaddr bits above log2(2*SIZE*SIZE) SHALL be 0.

Reset
REQ-031 While reset=0, and asynchronously on its falling edge: state=LOAD; cnt, idx=0; s_ready=0 until the first clock after release.
REQ-032 Output reset values SHALL be: awaddr, wdata, araddr, m_data = 0; awready, wready, m_valid, m_last, busy, timeout = 0.
REQ-033 Reset mid-job SHALL abandon the job; no partial write strobe SHALL follow release.

Configuration
REQ-034 With macro MXU_HOST_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT; on reaching TIMEOUT_CYCLES, the FSM SHALL go to LOAD and set output timeout (1 bit, sticky until reset).
REQ-035 Without MXU_HOST_TIMEOUT_EN, WAIT SHALL wait indefinitely, the port timeout SHALL still exist, and it SHALL be tied to 0.

Verification
REQ-036 SIZE=4, 32 bytes 0x01..0x20 streamed with s_valid held high -> 32 single-cycle strobes with awaddr 1..32 and wdata 0x001..0x020, then awaddr=0/wdata=0x001, then WAIT.
REQ-037 mxu_done pulsed, rdata=araddr*3, m_ready=1 -> m_data 0,3,...,45 in order, m_last only on 45, 3 cycles per word.
REQ-038 m_ready held low for 5 cycles in OUT -> m_data, m_valid and m_last stable; araddr unchanged; no idx advance.
REQ-039 reset=0 asserted after 10 loaded bytes -> all outputs 0 immediately; the next job's first write uses awaddr=1.
REQ-040 With MXU_HOST_TIMEOUT_EN and TIMEOUT_CYCLES=16, mxu_done held low -> timeout=1 after 16 WAIT cycles, s_ready=1 the cycle after; without the macro, timeout stays 0 and WAIT persists.
